load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//  Executes the mem_oper_t operations emitted by decode. Sits between the execute/mem stage and the
//  data-memory bus. Accepts one request at a time and drives a word-aligned bus transaction with
//  byte enables. Returns sign- or zero-extended load data, or a store completion.
//  Misaligned and undefined operations are rejected without touching the bus.
// PARAMETERS
//  ADDR_W  32  byte-address width; bus address is word aligned, so addr[1:0] are always 0
//  DATA_W  32  data width; fixed at 32 because lane logic assumes 4 byte lanes
// PORTS
//  clk_i         in   1       core clock; all state updates on the rising edge
//  rstn_i        in   1       reset, asynchronous, active-low
//  req_valid_i   in   1       pipeline presents a memory operation
//  req_ready_o   out  1       unit can accept; high only in IDLE
//  req_oper_i    in   4       mem_oper_t (MEM_LB..MEM_SW, MEM_NOP)
//  req_addr_i    in   ADDR_W  byte address
//  req_wdata_i   in   DATA_W  store data, right-aligned (rs2)
//  rsp_valid_o   out  1       single-cycle completion pulse
//  rsp_rdata_o   out  DATA_W  extended load result; 0 for stores, NOP and errors
//  rsp_err_o     out  1       misaligned or undefined oper; qualified by rsp_valid_o
//  mem_req_o     out  1       bus request; held until mem_gnt_i
//  mem_we_o      out  1       1 = write
//  mem_addr_o    out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
//  mem_be_o      out  4       byte enables
//  mem_wdata_o   out  DATA_W  lane-replicated store data
//  mem_gnt_i     in   1       bus accepted request
//  mem_rvalid_i  in   1       bus response (loads and stores), mem_rdata_i valid
//  mem_rdata_i   in   DATA_W  full read word
// BEHAVIOUR
//  Reset: IDLE; req_ready_o=1; rsp_valid_o=0, rsp_err_o=0; mem_req_o=0, mem_we_o=0;
//   rsp_rdata_o, mem_addr_o, mem_be_o and mem_wdata_o all 0.
//  FSM: IDLE -> ISSUE -> WAIT -> IDLE; accept = req_valid_i & req_ready_o.
//  IDLE, accept:
//   - MEM_NOP: no bus access; rsp_valid_o=1 next cycle, rsp_rdata_o=0, rsp_err_o=0; stay IDLE.
//   - undefined code, or misaligned access: no bus access; rsp_valid_o=1 and rsp_err_o=1
//     next cycle; rsp_rdata_o=0; stay IDLE.
//     Misaligned = H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0.
//   - otherwise: register oper, addr[1:0], address, be and wdata -> ISSUE.
//  ISSUE: mem_req_o=1; addr, we, be and wdata held stable.
//   - mem_gnt_i=1 -> WAIT.
//   - mem_gnt_i=1 and mem_rvalid_i=1 in the same cycle -> complete directly to IDLE.
//  WAIT: mem_req_o=0; mem_rvalid_i=1 -> IDLE, with rsp_valid_o=1 on the following cycle.
//  Minimum latency, accept to rsp_valid_o: 2 cycles with zero-wait bus. rsp_valid_o is registered.
//  Byte enables (off = addr[1:0]):
//   - B: 4'b0001<<off; H: 4'b0011<<off; W: 4'b1111.
//   - Loads use the same enables as stores.
//  Store data: SB = {4{wdata[7:0]}}; SH = {2{wdata[15:0]}}; SW = wdata.
//  Load data: select the byte or half at off.
//   - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
//   - Stores return rdata 0.
//  Boundary conditions:
//   - No back-to-back accept: req_ready_o=0 in ISSUE and WAIT, so it drops the cycle after accept.
//   - mem_rvalid_i in IDLE or ISSUE (without gnt) is ignored.
//   - Reset mid-transaction aborts: mem_req_o drops asynchronously; no response is issued;
//     a late mem_rvalid_i is ignored.
// STRUCTURE
//  riscv_pkg additions:
//   - lsu_state_t {LSU_IDLE, LSU_ISSUE, LSU_WAIT}.
//   - Function is_store(mem_oper_t) = oper[3] & oper!=MEM_NOP.
//   - Function size field = oper[1:0].
//  Sub-module mem_lane_align (combinational): be and wdata generation, plus load extraction
//   and extension. Pure function of oper, off and data.
// TESTING
//  1. LB @0x103, rdata 0x80FF_0000 -> be=1000, addr=0x100, rsp_rdata=0xFFFF_FF80.
//  2. LHU @0x102, rdata 0x8001_1234 -> be=1100, rsp_rdata=0x0000_8001;
//     LH at the same address -> 0xFFFF_8001.
//  3. SB @0x201, wdata 0x0000_00AB -> we=1, be=0010, mem_wdata=0xABAB_ABAB, rsp_rdata=0, err=0.
//  4. LW @0x302 -> no mem_req_o, rsp_valid=1 and err=1 one cycle later;
//     SH @0x305 -> same; oper 4'b0011 -> same.
//  5. gnt delayed 3 cycles, then rvalid 2 cycles later ->
//     addr, be, wdata and we stable while mem_req_o=1; req_ready_o=0 throughout;
//     exactly one rsp pulse.
//  6. rstn_i low while in WAIT, then rvalid pulse after release ->
//     outputs at reset values, no rsp_valid_o; next LW @0x0 completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared types and helpers for the load/store unit.
// - mem_oper_t  : memory operation codes from decode.
//                 bit 3 = store, bit 2 = unsigned load, bits 1:0 = access size.
// - lsu_state_t : request sequencing states.
// - helpers     : store/size decode, legality and alignment checks.
package load_store_unit_pkg;

    typedef enum logic [3:0] {
        MEM_LB  = 4'b0000,
        MEM_LH  = 4'b0001,
        MEM_LW  = 4'b0010,
        MEM_LBU = 4'b0100,
        MEM_LHU = 4'b0101,
        MEM_SB  = 4'b1000,
        MEM_SH  = 4'b1001,
        MEM_SW  = 4'b1010,
        MEM_NOP = 4'b1111
    } mem_oper_t;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'b00,
        LSU_ISSUE = 2'b01,
        LSU_WAIT  = 2'b10
    } lsu_state_t;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    function automatic logic is_store(input logic [3:0] oper);
        return oper[3] & (oper != MEM_NOP);
    endfunction

    function automatic logic [1:0] oper_size(input logic [3:0] oper);
        return oper[1:0];
    endfunction

    function automatic logic oper_defined(input logic [3:0] oper);
        logic ok;
        case (oper)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU,
            MEM_SB, MEM_SH, MEM_SW, MEM_NOP: ok = 1'b1;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_misaligned(input logic [3:0] oper, input logic [1:0] off);
        logic bad;
        case (oper_size(oper))
            SIZE_H:  bad = off[0];
            SIZE_W:  bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_mem_lane_align.sv
// Byte-lane steering between the 32-bit bus word and right-aligned core data.
// Pure combinational function of oper, off and data.
//   oper_i  : mem_oper_t code
//   off_i   : byte offset within the word
//   wdata_i : right-aligned store data
//   rdata_i : full bus read word
//   be_o    : byte enables
//   wdata_o : lane-replicated store data
//   rdata_o : extracted and extended load data (0 for stores / NOP)
module mem_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [3:0]  oper_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // A halfword access is aligned, so only off[1] picks the half.
    assign byte_s = rdata_i[{off_i, 3'b000} +: 8];
    assign half_s = rdata_i[{off_i[1], 4'b0000} +: 16];

    // Byte enables, store replication and load extension by access size.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = 32'h0000_0000;
        rdata_o = 32'h0000_0000;
        case (oper_size(oper_i))
            SIZE_B: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = oper_i[2] ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
            end
            SIZE_H: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = oper_i[2] ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
            end
            SIZE_W: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = 32'h0000_0000;
                rdata_o = 32'h0000_0000;
            end
        endcase
        if (is_store(oper_i)) begin
            rdata_o = 32'h0000_0000;
        end else begin
            rdata_o = rdata_o;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory operation at a time from the pipeline,
// runs a single word-aligned bus transaction and returns a one-cycle response.
// Illegal or misaligned operations, and NOPs, respond without touching the bus.
//   clk_i/rstn_i           : clock, asynchronous active-low reset
//   req_*                  : request from the pipeline (valid/ready handshake)
//   rsp_*                  : registered completion pulse, load data, error flag
//   mem_req_o .. mem_wdata_o : bus request, held until mem_gnt_i
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i : bus grant and response
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        req_oper_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    lsu_state_t        state_q, state_d;
    logic [3:0]        oper_q, oper_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    logic              accept_s;
    logic [3:0]        align_oper_s;
    logic [1:0]        align_off_s;
    logic [3:0]        align_be_s;
    logic [DATA_W-1:0] align_wdata_s;
    logic [DATA_W-1:0] align_rdata_s;

    assign req_ready_o = (state_q == LSU_IDLE);
    assign accept_s    = req_valid_i & req_ready_o;

    // In IDLE the aligner encodes the incoming request; once busy it decodes
    // the read word for the registered operation.
    assign align_oper_s = (state_q == LSU_IDLE) ? req_oper_i       : oper_q;
    assign align_off_s  = (state_q == LSU_IDLE) ? req_addr_i[1:0]  : off_q;

    mem_lane_align u_align (
        .oper_i  (align_oper_s),
        .off_i   (align_off_s),
        .wdata_i (req_wdata_i),
        .rdata_i (mem_rdata_i),
        .be_o    (align_be_s),
        .wdata_o (align_wdata_s),
        .rdata_o (align_rdata_s)
    );

    // Next-state and response logic.
    always_comb begin
        state_d     = state_q;
        oper_d      = oper_q;
        off_d       = off_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = {DATA_W{1'b0}};
        case (state_q)
            LSU_IDLE: begin
                if (!accept_s) begin
                    state_d = LSU_IDLE;
                end else if (req_oper_i == MEM_NOP) begin
                    rsp_valid_d = 1'b1;
                end else if (!oper_defined(req_oper_i) ||
                             is_misaligned(req_oper_i, req_addr_i[1:0])) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    oper_d  = req_oper_i;
                    off_d   = req_addr_i[1:0];
                    addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
                    be_d    = align_be_s;
                    wdata_d = align_wdata_s;
                    we_d    = is_store(req_oper_i);
                    state_d = LSU_ISSUE;
                end
            end
            LSU_ISSUE: begin
                // A response in the grant cycle completes the access at once;
                // rvalid without grant is not ours and is ignored.
                if (mem_gnt_i && mem_rvalid_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = align_rdata_s;
                    state_d     = LSU_IDLE;
                end else if (mem_gnt_i) begin
                    state_d = LSU_WAIT;
                end else begin
                    state_d = LSU_ISSUE;
                end
            end
            LSU_WAIT: begin
                if (mem_rvalid_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = align_rdata_s;
                    state_d     = LSU_IDLE;
                end else begin
                    state_d = LSU_WAIT;
                end
            end
            default: begin
                state_d = LSU_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= LSU_IDLE;
            oper_q      <= 4'b0000;
            off_q       <= 2'b00;
            addr_q      <= {ADDR_W{1'b0}};
            be_q        <= 4'b0000;
            wdata_q     <= {DATA_W{1'b0}};
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            oper_q      <= oper_d;
            off_q       <= off_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign mem_req_o   = (state_q == LSU_ISSUE);
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_be_o    = be_q;
    assign mem_wdata_o = wdata_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_rdata_o = rsp_rdata_q;

endmodule
